pipe_stage_elastic: RTL and testbench

Parametrised, elastic pipeline register for the pipelined MIPS datapath. It is the successor to the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers. It carries an arbitrary-width control bundle and data bundle with a valid/ready handshake and a 2-entry skid buffer, so back-pressure can propagate stage-by-stage without combinational ready chains. It also provides synchronous flush (bubble insertion) and forces control outputs to an idle pattern whenever the stage is empty, so bubbles never assert RegWrite/MemWrite downstream.

---
 rtl/pipe_stage_elastic.sv | 139 +++++++++++++
 tb/tb_pipe_stage_elastic.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake, 2-entry skid buffer, flush, idle-gated control.
// Optional stall/bubble performance counters are built when PIPE_STAGE_PERF_EN is defined.
//
// state | meaning
// EMPTY | no entry held; outputs idle
// ONE   | main entry valid, skid free
// FULL  | main and skid valid; in_ready low
module pipe_stage_elastic #(
  parameter int                CTRL_W    = 6,
  parameter int                DATA_W    = 111,
  parameter logic [CTRL_W-1:0] CTRL_IDLE = {CTRL_W{1'b0}},
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
`endif
);

  // Encoding is {skid_valid, main_valid}; 2'b10 is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state_q, state_d;
  logic              in_ready_q;
  logic              main_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              in_fire, out_fire;
  logic              load_main, load_skid, move_skid;

  assign main_valid = state_q[0];
  assign in_fire    = in_valid && in_ready_q;
  assign out_fire   = main_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          move_skid = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush kills held entries and any beat accepted this cycle.
    if (flush) state_d = EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (move_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_IDLE;
  assign out_data  = main_data;

`ifdef PIPE_STAGE_PERF_EN
  // Saturating counters; flush does not clear them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (!main_valid && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Self-checking bench for pipe_stage_elastic: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations (streaming, back-pressure, flush, reset).
module tb_pipe_stage_elastic;

  localparam int CW = 6;
  localparam int DW = 111;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0]   stall_cnt, bubble_cnt;
  logic          s_in_ready, s_out_valid;
  logic [CW-1:0] s_out_ctrl;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_stall_cnt, s_bubble_cnt;
`endif

  pipe_stage_elastic dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

`ifdef PIPE_STAGE_PERF_EN
  pipe_stage_elastic #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_ctrl(s_out_ctrl), .out_data(s_out_data),
    .stall_cnt(s_stall_cnt), .bubble_cnt(s_bubble_cnt)
  );
`endif

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of at most two beats.
  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } beat_t;

  beat_t q[$];
  int    m_stall, m_bubble;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_stall  = 0;
      m_bubble = 0;
    end else begin
      automatic bit has   = (q.size() > 0);
      automatic bit space = (q.size() < 2);
      if (has && !out_ready) m_stall++;
      if (!has) m_bubble++;
      if (has && out_ready) void'(q.pop_front());
      if (flush) q.delete();
      else if (in_valid && space) q.push_back('{c: in_ctrl, d: in_data});
    end
  end

  function automatic int sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  always @(negedge clk) begin
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_ctrl", out_ctrl, (q.size() > 0) ? q[0].c : '0);
    if (q.size() > 0) chk("out_data", out_data, q[0].d);
`ifdef PIPE_STAGE_PERF_EN
    chk("stall_cnt", stall_cnt, sat(m_stall, 16));
    chk("bubble_cnt", bubble_cnt, sat(m_bubble, 16));
    chk("sat_stall_cnt", s_stall_cnt, sat(m_stall, 2));
    chk("sat_bubble_cnt", s_bubble_cnt, sat(m_bubble, 2));
`endif
  end

  // Delivered-beat log taken from the DUT, compared against literal sequences.
  logic [DW-1:0] log_d[$];
  int            log_c[$];
  int            cyc = 0;

  always @(posedge clk) begin
    cyc++;
    if (!rst && out_valid && out_ready) begin
      log_d.push_back(out_data);
      log_c.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [DW-1:0] d);
    logic acc;
    int   n;
    in_ctrl  = c;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      acc = in_ready;
      tick();
      n++;
    end while (!acc && n < 50);
    chk("send_accept", acc, 1'b1);
  endtask

  int base;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_ctrl", out_ctrl, 6'h00);
    chk("rst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b0;

    // Streaming: 8 back-to-back beats with out_ready high.
    out_ready = 1'b1;
    base = log_d.size();
    for (int i = 1; i <= 8; i++) send(CW'(i + 8), DW'(i));
    in_valid = 1'b0;
    tick(); tick();
    chk("stream_count", log_d.size() - base, 8);
    if (log_d.size() >= base + 8)
      for (int i = 0; i < 8; i++) begin
        chk("stream_data", log_d[base+i], i + 1);
        chk("stream_cycle", log_c[base+i] - log_c[base], i);
      end

    // Back-pressure: 1,2 fill the stage, 3 is held on the input.
    out_ready = 1'b0;
    base = log_d.size();
    send(6'h01, 1); send(6'h02, 2);
    in_ctrl = 6'h03; in_data = 3;
    tick(); tick();
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", out_data, 1);
    out_ready = 1'b1;
    send(6'h03, 3);
    in_valid = 1'b0;
    tick(); tick();
    chk("bp_count", log_d.size() - base, 3);
    if (log_d.size() >= base + 3)
      for (int i = 0; i < 3; i++) chk("bp_order", log_d[base+i], i + 1);

    // Flush from FULL with beat 6 presented.
    out_ready = 1'b0;
    base = log_d.size();
    send(6'h04, 4); send(6'h05, 5);
    in_ctrl = 6'h06; in_data = 6; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_out_ctrl", out_ctrl, 6'h00);
    chk("flush_in_ready", in_ready, 1'b1);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_none", log_d.size() - base, 0);

    // Flush in ONE: the out_fire of 7 counts, the incoming 8 is dropped.
    base = log_d.size();
    send(6'h07, 7);
    in_ctrl = 6'h08; in_data = 8; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    tick(); tick();
    chk("flush_one_count", log_d.size() - base, 1);
    if (log_d.size() > base) chk("flush_one_beat", log_d[base], 7);

    // Bubble gating of control.
    send(6'h3f, 9);
    in_valid = 1'b0;
    chk("gate_live_ctrl", out_ctrl, 6'h3f);
    tick();
    chk("gate_idle_ctrl", out_ctrl, 6'h00);
    chk("gate_idle_valid", out_valid, 1'b0);

    // Asynchronous reset in FULL, then latency and counters after release.
    out_ready = 1'b0;
    send(6'h11, 'h11); send(6'h22, 'h22);
    in_valid = 1'b0;
    chk("full_in_ready", in_ready, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_out_ctrl", out_ctrl, 6'h00);
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    tick(); tick();
    in_ctrl = 6'h15; in_data = 'ha5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a5_valid", out_valid, 1'b1);
    chk("a5_data", out_data, 'ha5);
    for (int i = 0; i < 5; i++) tick();
`ifdef PIPE_STAGE_PERF_EN
    chk("perf_stall", stall_cnt, 5);
    chk("perf_bubble", bubble_cnt, 3);
    chk("perf_sat_stall", s_stall_cnt, 3);
`endif
    out_ready = 1'b1;
    tick(); tick();
    chk("drain_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
